// File: rtl/valve_cmd_pkg.sv
// Shared types and constants for the valve command sequencer:
// FSM states, decoded byte tokens, ASCII command bytes and error codes.
package valve_cmd_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    APPLY   = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    BIT0  = 3'd0,
    BIT1  = 3'd1,
    START = 3'd2,
    SEND  = 3'd3,
    BAD   = 3'd4
  } tok_t;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_ONE   = 8'h31;
  localparam logic [7:0] ASCII_START = 8'h6D;
  localparam logic [7:0] ASCII_SEND  = 8'h73;

  localparam logic [1:0] ERR_BAD      = 2'b00;
  localparam logic [1:0] ERR_SHORT    = 2'b01;
  localparam logic [1:0] ERR_OVERFLOW = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

endpackage

// File: rtl/cmd_decode.sv
// Combinational classifier turning one received ASCII byte into a token.
module cmd_decode
  import valve_cmd_pkg::*;
(
  input  logic [7:0] rx_data_i,
  output tok_t       tok_o
);

  // Map the four command characters; everything else is a bad byte.
  always_comb begin
    tok_o = BAD;
    case (rx_data_i)
      ASCII_ZERO:  tok_o = BIT0;
      ASCII_ONE:   tok_o = BIT1;
      ASCII_START: tok_o = START;
      ASCII_SEND:  tok_o = SEND;
      default:     tok_o = BAD;
    endcase
  end

endmodule

// File: rtl/valve_cmd_sequencer.sv
// Collects an ASCII valve frame ('m', NUM_VALVES bits, 's') into a shadow
// register and applies it to the valve outputs in one cycle; reports
// malformed frames and inter-byte timeouts through err_pulse/err_code.
module valve_cmd_sequencer
  import valve_cmd_pkg::*;
#(
  parameter int NUM_VALVES     = 16,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [NUM_VALVES-1:0] valve_state,
  output logic                  update_pulse,
  output logic                  busy,
  output logic                  err_pulse,
  output logic [1:0]            err_code,
  output logic [7:0]            frame_cnt
);

  localparam int CNT_W = $clog2(NUM_VALVES + 1);
  localparam int IDX_W = (NUM_VALVES > 1) ? $clog2(NUM_VALVES) : 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_VALVES);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  state_t                  state_q;
  logic [NUM_VALVES-1:0]   shadow_q;
  logic [NUM_VALVES-1:0]   valve_q;
  logic [CNT_W-1:0]        bit_cnt_q;
  logic [TMO_W-1:0]        tmo_q;
  logic                    update_q;
  logic                    err_q;
  logic [1:0]              err_code_q;
  logic [7:0]              frame_cnt_q;
  logic                    busy_q;
  logic                    armed_q;
  tok_t                    tok;
  logic                    byte_v;

  cmd_decode u_decode (
    .rx_data_i (rx_data),
    .tok_o     (tok)
  );

  // The first edge after reset release only arms the input, so a byte
  // coincident with that edge is never acted upon.
  assign byte_v = rx_valid && armed_q;

  // Frame FSM with shadow collection, timeout counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      shadow_q    <= '0;
      valve_q     <= '0;
      bit_cnt_q   <= '0;
      tmo_q       <= '0;
      update_q    <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= ERR_BAD;
      frame_cnt_q <= 8'd0;
      busy_q      <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      update_q <= 1'b0;
      err_q    <= 1'b0;
      armed_q  <= 1'b1;
      case (state_q)
        // APPLY commits the frame and then behaves exactly like IDLE for
        // any byte arriving in the same cycle.
        IDLE, APPLY: begin
          if (state_q == APPLY) begin
            valve_q     <= shadow_q;
            update_q    <= 1'b1;
            frame_cnt_q <= frame_cnt_q + 8'd1;
          end
          state_q <= IDLE;
          busy_q  <= 1'b0;
          if (byte_v && tok == START) begin
            shadow_q  <= '0;
            bit_cnt_q <= '0;
            tmo_q     <= '0;
            state_q   <= COLLECT;
            busy_q    <= 1'b1;
          end
        end
        COLLECT: begin
          if (byte_v) begin
            tmo_q <= '0;
            case (tok)
              BIT0, BIT1: begin
                if (bit_cnt_q == FULL_CNT) begin
                  err_q      <= 1'b1;
                  err_code_q <= ERR_OVERFLOW;
                  state_q    <= IDLE;
                  busy_q     <= 1'b0;
                end else begin
                  shadow_q[bit_cnt_q[IDX_W-1:0]] <= (tok == BIT1);
                  bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                end
              end
              SEND: begin
                if (bit_cnt_q == FULL_CNT) begin
                  state_q <= APPLY;
                end else begin
                  err_q      <= 1'b1;
                  err_code_q <= ERR_SHORT;
                  state_q    <= IDLE;
                end
                busy_q <= 1'b0;
              end
              START: begin
                shadow_q  <= '0;
                bit_cnt_q <= '0;
              end
              default: begin
                err_q      <= 1'b1;
                err_code_q <= ERR_BAD;
                state_q    <= IDLE;
                busy_q     <= 1'b0;
              end
            endcase
          end else if (tmo_q == TMO_LAST) begin
            err_q      <= 1'b1;
            err_code_q <= ERR_TIMEOUT;
            state_q    <= IDLE;
            busy_q     <= 1'b0;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign valve_state  = valve_q;
  assign update_pulse = update_q;
  assign busy         = busy_q;
  assign err_pulse    = err_q;
  assign err_code     = err_code_q;
  assign frame_cnt    = frame_cnt_q;

endmodule

// File: tb/tb_valve_cmd_sequencer.sv
// Bench for valve_cmd_sequencer (NUM_VALVES=4, TIMEOUT_CYCLES=100).
// Expected pulses are queued when the triggering byte is driven and
// checked, including their cycle of arrival, when the DUT pulses.
module tb_valve_cmd_sequencer;

  localparam int NV  = 4;
  localparam int TMO = 100;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic [NV-1:0] valve_state;
  logic          update_pulse;
  logic          busy;
  logic          err_pulse;
  logic [1:0]    err_code;
  logic [7:0]    frame_cnt;

  valve_cmd_sequencer #(.NUM_VALVES(NV), .TIMEOUT_CYCLES(TMO)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .valve_state  (valve_state),
    .update_pulse (update_pulse),
    .busy         (busy),
    .err_pulse    (err_pulse),
    .err_code     (err_code),
    .frame_cnt    (frame_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       is_upd;
    logic [1:0] code;
    logic [3:0] valves;
    logic [7:0] fcnt;
    int         at;
  } ev_t;

  typedef struct {
    string      s;
    int         ref_idx;
    int         ofs;
    int         kind;    // 0 none, 1 update, 2 error
    logic [1:0] code;
    logic [3:0] valves;
    logic [7:0] fcnt;
    int         idle;
  } vec_t;

  ev_t  evq[$];
  vec_t vt[8];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Called at a falling edge: the next rising edge is cyc+1.
  task automatic push_ev(input logic is_upd, input logic [1:0] code,
                         input logic [3:0] valves, input logic [7:0] fcnt, input int ofs);
    ev_t e;
    e.is_upd = is_upd;
    e.code   = code;
    e.valves = valves;
    e.fcnt   = fcnt;
    e.at     = cyc + 1 + ofs;
    evq.push_back(e);
  endtask

  // Drive one byte for exactly one rising edge; call and return on a falling edge.
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  // Scoreboard: every pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (update_pulse && err_pulse) chk("pulse_overlap", 32'(1), 32'(0));
      if (update_pulse || err_pulse) begin
        if (evq.size() == 0) begin
          chk(update_pulse ? "unexpected_update" : "unexpected_err", 32'(1), 32'(0));
        end else begin
          ev_t e;
          e = evq.pop_front();
          chk("ev_kind_is_update", 32'(update_pulse), 32'(e.is_upd));
          chk("ev_cycle", 32'(cyc), 32'(e.at));
          if (!e.is_upd) chk("ev_err_code", 32'(err_code), 32'(e.code));
          chk("ev_valve_state", 32'(valve_state), 32'(e.valves));
          chk("ev_frame_cnt", 32'(frame_cnt), 32'(e.fcnt));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    string      s;
    vec_t       cv;
    logic [3:0] p;

    vt[0] = '{"m1011s",    5, 1,   1, 2'b00, 4'b1101, 8'd1, 3};
    vt[1] = '{"m10s",      3, 0,   2, 2'b01, 4'b1101, 8'd1, 3};
    vt[2] = '{"m11110s",   5, 0,   2, 2'b10, 4'b1101, 8'd1, 3};
    vt[3] = '{"m1x",       2, 0,   2, 2'b00, 4'b1101, 8'd1, 3};
    vt[4] = '{"m01",       2, TMO, 2, 2'b11, 4'b1101, 8'd1, TMO + 5};
    vt[5] = '{"m11m0010s", 8, 1,   1, 2'b00, 4'b0100, 8'd2, 3};
    vt[6] = '{"x1sm0000s", 8, 1,   1, 2'b00, 4'b0000, 8'd3, 3};
    vt[7] = '{"mm1111s",   6, 1,   1, 2'b00, 4'b1111, 8'd4, 3};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_valve_state", 32'(valve_state), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_frame_cnt", 32'(frame_cnt), 32'(0));
    chk("rst_err_code", 32'(err_code), 32'(0));
    chk("rst_pulses", 32'({update_pulse, err_pulse}), 32'(0));
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Table-driven frames
    for (int v = 0; v < 8; v++) begin
      cv = vt[v];
      s  = cv.s;
      for (int i = 0; i < s.len(); i++) begin
        if (i == cv.ref_idx && cv.kind != 0)
          push_ev(cv.kind == 1, cv.code, cv.valves, cv.fcnt, cv.ofs);
        send_byte(s.getc(i));
      end
      repeat (cv.idle) @(negedge clk);
      chk("vec_valve_state", 32'(valve_state), 32'(cv.valves));
      chk("vec_frame_cnt", 32'(frame_cnt), 32'(cv.fcnt));
      chk("vec_busy", 32'(busy), 32'(0));
      chk("vec_events_drained", 32'(evq.size()), 32'(0));
    end

    // START arriving in the APPLY cycle opens the next frame immediately
    send_byte("m");
    chk("busy_collect", 32'(busy), 32'(1));
    s = "1111";
    for (int i = 0; i < 4; i++) send_byte(s.getc(i));
    push_ev(1'b1, 2'b00, 4'b1111, 8'd5, 1);
    send_byte("s");
    send_byte("m");
    chk("busy_after_apply_start", 32'(busy), 32'(1));
    s = "0001";
    for (int i = 0; i < 4; i++) send_byte(s.getc(i));
    push_ev(1'b1, 2'b00, 4'b1000, 8'd6, 1);
    send_byte("s");
    repeat (3) @(negedge clk);
    chk("apply_chain_valves", 32'(valve_state), 32'(4'b1000));
    chk("apply_chain_drained", 32'(evq.size()), 32'(0));

    // Reset mid-frame clears everything at once and drops the partial frame
    send_byte("m");
    send_byte("1");
    send_byte("1");
    rst = 1'b1;
    #1;
    chk("midrst_valve_state", 32'(valve_state), 32'(0));
    chk("midrst_frame_cnt", 32'(frame_cnt), 32'(0));
    chk("midrst_busy", 32'(busy), 32'(0));
    chk("midrst_err_code", 32'(err_code), 32'(0));
    chk("midrst_pulses", 32'({update_pulse, err_pulse}), 32'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    send_byte("m");
    chk("first_edge_ignored", 32'(busy), 32'(0));
    @(negedge clk);
    s = "m0110";
    for (int i = 0; i < 5; i++) send_byte(s.getc(i));
    push_ev(1'b1, 2'b00, 4'b0110, 8'd1, 1);
    send_byte("s");
    repeat (3) @(negedge clk);
    chk("post_rst_valves", 32'(valve_state), 32'(4'b0110));
    chk("post_rst_frame_cnt", 32'(frame_cnt), 32'(1));

    // 255 more good frames: frame_cnt wraps from 255 to 0
    for (int f = 1; f <= 255; f++) begin
      p = 4'(f);
      send_byte("m");
      for (int b = 0; b < 4; b++) send_byte(p[b] ? 8'h31 : 8'h30);
      push_ev(1'b1, 2'b00, p, 8'((1 + f) % 256), 1);
      send_byte("s");
    end
    repeat (3) @(negedge clk);
    chk("wrap_frame_cnt", 32'(frame_cnt), 32'(0));
    chk("wrap_valves", 32'(valve_state), 32'(4'b1111));
    chk("wrap_drained", 32'(evq.size()), 32'(0));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
